// File: rtl/cei_mochila_pkg.sv
// -----------------------------------------------------------------------------
// cei_mochila_pkg
// SoC-level peripheral indices and the address rules used by the peripheral
// reg_demux. The timer occupies its own 4 KiB window.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cei_mochila_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    localparam int unsigned SOC_CTRL_IDX = 0;
    localparam int unsigned GPIO_IDX     = 1;
    localparam int unsigned TIMER_IDX    = 2;
    localparam int unsigned PERIPHERALS  = 3;

    localparam addr_rule_t PERIPHERALS_ADDR_RULES [PERIPHERALS] = '{
        '{idx: SOC_CTRL_IDX, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000},
        '{idx: GPIO_IDX,     start_addr: 32'h2000_1000, end_addr: 32'h2000_2000},
        '{idx: TIMER_IDX,    start_addr: 32'h2000_2000, end_addr: 32'h2000_3000}
    };

endpackage

// File: rtl/mochila_timer_pkg.sv
// -----------------------------------------------------------------------------
// mochila_timer_pkg
// Register offsets, CTRL/STATUS bit positions, FSM state type and a byte-strobe
// merge helper for mochila_timer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mochila_timer_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COMPARE  = 5'h08;
    localparam logic [4:0] OFF_COUNT    = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned STATUS_MATCH  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Register-bus request/response types shared by the peripheral subsystem.
// The request carries a byte-strobed 32-bit write or read. The response carries
// read data, an error flag and a ready flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/mochila_timer_if.sv
// -----------------------------------------------------------------------------
// mochila_timer_if
// Register-bus bundle for the timer: req (master -> slave), rsp (slave ->
// master). The master modport belongs to the bus initiator, slave to the timer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mochila_timer_if;
    import reg_pkg::*;

    reg_req_t req;
    reg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/mochila_timer_prescaler.sv
// -----------------------------------------------------------------------------
// mochila_timer_prescaler
// Prescale counter and tick generation.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   i_run          timer is in RUN; the counter advances only then
//   i_clear        force the counter back to 0 (EN leaving 1)
//   i_prescale     terminal value; tick fires when the counter equals it
//   o_tick         one-cycle COUNT advance strobe
// Build option: MOCHILA_TIMER_PRESCALER_EN. When undefined the counter is not
// built and o_tick follows i_run, i.e. one tick every RUN cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mochila_timer_prescaler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_run,
    input  logic        i_clear,
    input  logic [15:0] i_prescale,
    output logic        o_tick
);

`ifdef MOCHILA_TIMER_PRESCALER_EN
    logic [15:0] r_cnt;

    assign o_tick = i_run && (r_cnt == i_prescale);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? 16'd0 : r_cnt + 16'd1;
        end
    end
`else
    logic w_unused;

    assign o_tick   = i_run;
    assign w_unused = ^{clk_i, rst_ni, i_clear, i_prescale};
`endif

endmodule

// File: rtl/mochila_timer.sv
// -----------------------------------------------------------------------------
// mochila_timer
// 32-bit compare timer on the peripheral register bus.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   reg_req_i  register-bus request (req_t)
//   reg_rsp_o  register-bus response (rsp_t); always ready, rdata combinational
//   irq_o      level interrupt = MATCH & IRQ_EN
// Map (addr[4:2]): 0x00 CTRL {IRQ_EN,PERIODIC,EN}, 0x04 PRESCALE[15:0],
//   0x08 COMPARE, 0x0C COUNT, 0x10 STATUS {MATCH} (write-1-to-clear).
// Build option: MOCHILA_TIMER_PRESCALER_EN enables the PRESCALE register and
// the prescale counter; otherwise PRESCALE reads 0 and COUNT ticks every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mochila_timer
    import mochila_timer_pkg::*;
#(
    parameter type req_t = reg_pkg::reg_req_t,
    parameter type rsp_t = reg_pkg::reg_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t reg_req_i,
    output rsp_t reg_rsp_o,
    output logic irq_o
);

    timer_state_e r_state, w_state_nxt;
    logic         r_periodic, r_irq_en, r_match;
    logic [31:0]  r_compare, r_count;
    logic [15:0]  w_prescale;

    logic [4:0] w_off;
    logic       w_mapped, w_wr;
    logic       w_wr_ctrl, w_wr_prescale, w_wr_compare, w_wr_count, w_wr_status;
    logic       w_en_set, w_en_clr, w_clr_match;
    logic       w_run, w_tick, w_hit, w_presc_clear;
    logic       w_unused_addr;

    // Byte lanes inside a word are not decoded.
    assign w_off         = {reg_req_i.addr[4:2], 2'b00};
    assign w_unused_addr = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0]};

    assign w_mapped = (w_off == OFF_CTRL)    || (w_off == OFF_PRESCALE) ||
                      (w_off == OFF_COMPARE) || (w_off == OFF_COUNT)    ||
                      (w_off == OFF_STATUS);

    assign w_wr          = reg_req_i.valid && reg_req_i.write;
    assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
    assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);
    assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
    assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
    assign w_wr_status   = w_wr && (w_off == OFF_STATUS);

    assign w_en_set    = w_wr_ctrl && reg_req_i.wstrb[0] &&  reg_req_i.wdata[CTRL_EN];
    assign w_en_clr    = w_wr_ctrl && reg_req_i.wstrb[0] && !reg_req_i.wdata[CTRL_EN];
    assign w_clr_match = w_wr_status && reg_req_i.wstrb[0] && reg_req_i.wdata[STATUS_MATCH];

    // EN has no flop of its own: it is exactly "FSM is in RUN".
    assign w_run = (r_state == ST_RUN);
    assign w_hit = w_tick && (r_count == r_compare);

    // The prescale counter restarts from 0 whenever the timer stops running.
    assign w_presc_clear = (w_state_nxt != ST_RUN);

    mochila_timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_run      (w_run),
        .i_clear    (w_presc_clear),
        .i_prescale (w_prescale),
        .o_tick     (w_tick)
    );

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_en_set) w_state_nxt = ST_RUN;
            // A software write to EN takes priority over a one-shot completion.
            ST_RUN: begin
                if (w_en_clr)                             w_state_nxt = ST_IDLE;
                else if (!w_en_set && w_hit && !r_periodic) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_en_set)      w_state_nxt = ST_RUN;
                else if (w_en_clr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_compare  <= '0;
            r_count    <= '0;
            r_match    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_ctrl && reg_req_i.wstrb[0]) begin
                r_periodic <= reg_req_i.wdata[CTRL_PERIODIC];
                r_irq_en   <= reg_req_i.wdata[CTRL_IRQ_EN];
            end
            if (w_wr_compare) begin
                r_compare <= apply_wstrb(r_compare, reg_req_i.wdata, reg_req_i.wstrb);
            end
            // Software write wins over the tick's increment or reload.
            if (w_wr_count) begin
                r_count <= apply_wstrb(r_count, reg_req_i.wdata, reg_req_i.wstrb);
            end else if (w_tick) begin
                if (!w_hit)          r_count <= r_count + 32'd1;
                else if (r_periodic) r_count <= '0;
            end
            // A new match beats a simultaneous write-1-to-clear.
            r_match <= w_hit || (r_match && !w_clr_match);
        end
    end

`ifdef MOCHILA_TIMER_PRESCALER_EN
    logic [15:0] r_prescale;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            if (reg_req_i.wstrb[0]) r_prescale[7:0]  <= reg_req_i.wdata[7:0];
            if (reg_req_i.wstrb[1]) r_prescale[15:8] <= reg_req_i.wdata[15:8];
        end
    end

    assign w_prescale = r_prescale;
`else
    logic w_unused_presc;

    assign w_prescale     = 16'h0000;
    assign w_unused_presc = w_wr_prescale;
`endif

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = reg_req_i.valid && !w_mapped;
        case (w_off)
            OFF_CTRL: begin
                reg_rsp_o.rdata[CTRL_EN]       = w_run;
                reg_rsp_o.rdata[CTRL_PERIODIC] = r_periodic;
                reg_rsp_o.rdata[CTRL_IRQ_EN]   = r_irq_en;
            end
            OFF_PRESCALE: reg_rsp_o.rdata[15:0] = w_prescale;
            OFF_COMPARE:  reg_rsp_o.rdata       = r_compare;
            OFF_COUNT:    reg_rsp_o.rdata       = r_count;
            OFF_STATUS:   reg_rsp_o.rdata[STATUS_MATCH] = r_match;
            default:      reg_rsp_o.rdata       = '0;
        endcase
    end

    assign irq_o = r_match && r_irq_en;

endmodule

// File: tb/tb_mochila_timer.sv
// -----------------------------------------------------------------------------
// tb_mochila_timer
// Directed bench for mochila_timer. Bus reads push their expected response to
// a scoreboard queue; a negedge monitor pops and compares it against the DUT.
// Honours MOCHILA_TIMER_PRESCALER_EN to pick tick period and PRESCALE readback.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mochila_timer;
    import reg_pkg::*;
    import mochila_timer_pkg::*;

    localparam logic [4:0] A_CTRL  = 5'h00;
    localparam logic [4:0] A_PRESC = 5'h04;
    localparam logic [4:0] A_CMP   = 5'h08;
    localparam logic [4:0] A_CNT   = 5'h0C;
    localparam logic [4:0] A_STAT  = 5'h10;
    localparam logic [4:0] A_BAD   = 5'h14;

`ifdef MOCHILA_TIMER_PRESCALER_EN
    localparam int          PER      = 4;
    localparam logic [31:0] PRESC_RB = 32'h0000_FFFF;
    localparam logic [31:0] PRESC_12 = 32'h0000_1234;
`else
    localparam int          PER      = 1;
    localparam logic [31:0] PRESC_RB = 32'h0;
    localparam logic [31:0] PRESC_12 = 32'h0;
`endif
    // First periodic match: three ticks (COUNT 0,1,2) with PRESCALE=3.
    localparam int M = 3 * PER;

    logic clk;
    logic rst_n;
    logic irq_o;

    mochila_timer_if bus ();

    mochila_timer dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .reg_req_i (bus.req),
        .reg_rsp_o (bus.rsp),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Response is combinational, so sample mid-cycle while the read is held.
    always @(negedge clk) begin
        if (bus.req.valid && !bus.req.write) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_rdata"}, bus.rsp.rdata, mon_e.rdata);
                check({mon_e.tag, "_err"}, 32'(bus.rsp.error), 32'(mon_e.error));
                check({mon_e.tag, "_rdy"}, 32'(bus.rsp.ready), 32'd1);
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data,
                             input logic [3:0] strb = 4'hF);
        bus.req.addr  = {27'd0, off};
        bus.req.write = 1'b1;
        bus.req.wdata = data;
        bus.req.wstrb = strb;
        bus.req.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req.valid = 1'b0;
        bus.req.write = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [4:0] off,
                            input logic [31:0] exp_data, input logic exp_err = 1'b0);
        exp_t e;
        e.tag   = tag;
        e.rdata = exp_data;
        e.error = exp_err;
        sb_q.push_back(e);
        bus.req.addr  = {27'd0, off};
        bus.req.write = 1'b0;
        bus.req.wdata = '0;
        bus.req.wstrb = '0;
        bus.req.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        #2;
        check("rst_irq", 32'(irq_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        bus_read("rst_ctrl",  A_CTRL,  32'h0);
        bus_read("rst_presc", A_PRESC, 32'h0);
        bus_read("rst_cmp",   A_CMP,   32'h0);
        bus_read("rst_cnt",   A_CNT,   32'h0);
        bus_read("rst_stat",  A_STAT,  32'h0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // S1: periodic, PRESCALE=3, COMPARE=2
        bus_write(A_PRESC, 32'd3);
        bus_write(A_CMP,   32'd2);
        bus_write(A_CTRL,  32'b111);
        check("s1_irq_pre", 32'(irq_o), 32'd0);
        wait_cycles(M - 2);
        bus_read("s1_stat_pre", A_STAT, 32'd0);
        bus_read("s1_cnt_pre",  A_CNT,  32'd2);
        bus_read("s1_stat_hit", A_STAT, 32'd1);
        check("s1_irq", 32'(irq_o), 32'd1);
        bus_write(A_STAT, 32'd1);
        check("s1_irq_clr", 32'(irq_o), 32'd0);
        wait_cycles(M - 3);
        bus_read("s1_stat_gap",  A_STAT, 32'd0);
        bus_read("s1_stat_hit2", A_STAT, 32'd1);
        bus_read("s1_cnt_after", A_CNT,  (PER == 1) ? 32'd1 : 32'd0);
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STAT, 32'd1);
        bus_write(A_CNT,  32'd0);

        // S2: one-shot, PRESCALE=0, COMPARE=5
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CMP,   32'd5);
        bus_write(A_CTRL,  32'b101);
        wait_cycles(4);
        bus_read("s2_stat_p5", A_STAT, 32'd0);
        bus_read("s2_stat_p6", A_STAT, 32'd0);
        bus_read("s2_stat_hit", A_STAT, 32'd1);
        bus_read("s2_ctrl",     A_CTRL, 32'b100);
        bus_read("s2_cnt",      A_CNT,  32'd5);
        check("s2_state_done", 32'(dut.r_state), 32'(ST_DONE));
        check("s2_irq", 32'(irq_o), 32'd1);
        wait_cycles(3);
        bus_read("s2_cnt_hold", A_CNT, 32'd5);
        bus_write(A_CTRL, 32'd0);
        check("s2_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        bus_write(A_STAT, 32'd1);

        // S3: COUNT wraps without a flag; software COUNT write beats a tick
        bus_write(A_CMP, 32'h10);
        bus_write(A_CNT, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'd1);
        bus_read("s3_cnt_max",  A_CNT,  32'hFFFF_FFFF);
        bus_read("s3_cnt_wrap", A_CNT,  32'h0);
        bus_read("s3_stat",     A_STAT, 32'd0);
        bus_write(A_CNT, 32'h100);
        bus_read("s3_cnt_sw",   A_CNT,  32'h100);
        bus_write(A_CTRL, 32'd0);

        // S4: W1C in the exact match cycle leaves MATCH set
        bus_write(A_CNT,  32'd0);
        bus_write(A_CMP,  32'd3);
        bus_write(A_CTRL, 32'b101);
        wait_cycles(3);
        bus_write(A_STAT, 32'd1);
        bus_read("s4_stat_race", A_STAT, 32'd1);
        check("s4_irq_race", 32'(irq_o), 32'd1);
        bus_write(A_STAT, 32'd1);
        bus_read("s4_stat_clr", A_STAT, 32'd0);
        check("s4_irq_clr", 32'(irq_o), 32'd0);
        bus_write(A_CTRL, 32'd0);

        // S5: unmapped offset, byte strobes, unused bits
        bus_write(A_CTRL,  32'b110);
        bus_write(A_PRESC, 32'h1234);
        bus_read("s5_bad_rd", A_BAD, 32'h0, 1'b1);
        bus_write(A_BAD, 32'hFFFF_FFFF);
        bus_read("s5_ctrl",  A_CTRL,  32'b110);
        bus_read("s5_presc", A_PRESC, PRESC_12);
        bus_read("s5_cmp",   A_CMP,   32'd3);
        bus_read("s5_cnt",   A_CNT,   32'd3);
        bus_read("s5_stat",  A_STAT,  32'd0);
        bus_write(A_CMP, 32'hAABB_CCDD, 4'b0010);
        bus_read("s5_cmp_strb", A_CMP, 32'h0000_CC03);
        bus_write(A_CTRL, 32'hFFFF_FFF8);
        bus_read("s5_ctrl_unused", A_CTRL, 32'h0);

        // S6: reset mid-count aborts everything
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CMP,   32'd1);
        bus_write(A_CNT,   32'd0);
        bus_write(A_CTRL,  32'b111);
        wait_cycles(4);
        check("s6_irq_run", 32'(irq_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_irq_rst", 32'(irq_o), 32'd0);
        bus_read("s6_ctrl_in_rst", A_CTRL, 32'h0);
        rst_n = 1'b1;
        bus_read("s6_ctrl",  A_CTRL,  32'h0);
        bus_read("s6_presc", A_PRESC, 32'h0);
        bus_read("s6_cmp",   A_CMP,   32'h0);
        bus_read("s6_cnt",   A_CNT,   32'h0);
        bus_read("s6_stat",  A_STAT,  32'h0);
        check("s6_state", 32'(dut.r_state), 32'(ST_IDLE));
        bus_write(A_PRESC, 32'h0000_FFFF);
        bus_read("s6_presc_ff", A_PRESC, PRESC_RB);
        wait_cycles(3);
        bus_read("s6_cnt_idle", A_CNT, 32'h0);
        check("s6_irq_after", 32'(irq_o), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
